ws2812_tx_ctrl: RTL and testbench
=================================

WS2812_TX_CTRL -- requirements
Module: ws2812_tx_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- T_BIT, 60, bit period in sys_clk cycles (1.2 us at 50 MHz)
- T0H, 18, high time of a '0' bit in cycles
- T1H, 40, high time of a '1' bit in cycles
- T_RST, 15000, latch/reset low time in cycles (300 us)
- LED_NUM, 64, pixels per frame

REQ-002 The block SHALL have these ports:
- sys_clk, input, 1, single clock, rising edge
- sys_rst_n, input, 1, asynchronous active-low reset
- ws2812_start, input, 1, single-cycle frame request pulse from the config module
- cfg_data, input, 24, pixel colour {G[7:0],R[7:0],B[7:0]} for the config module's current pixel index
- cfg_start, output, 1, single-cycle pulse: pixel consumed, config module advances its index
- ws2812_di, output, 1, serial data line to the LED chain
- busy, output, 1, high while a frame (including latch time) is in progress
- frame_done, output, 1, single-cycle pulse at the end of the latch period

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, SEND and RST.
REQ-004 IDLE: ws2812_di=0 and busy=0. On ws2812_start=1 the FSM SHALL go to LOAD, clear led_cnt, and set busy=1 on the next cycle.
REQ-005 LOAD lasts exactly 1 cycle. cfg_start SHALL be 1 in that cycle and only in LOAD. On the edge ending LOAD, the shift register SHALL capture cfg_data, bit_cnt and cyc_cnt SHALL clear, and the FSM SHALL go to SEND.
REQ-006 SEND SHALL transmit 24 bits MSB-first (G7 first, B0 last). Each bit lasts T_BIT cycles, counted by cyc_cnt from 0 to T_BIT-1.
REQ-007 Within a bit, ws2812_di SHALL be 1 while cyc_cnt < (bit ? T1H : T0H), and 0 otherwise.
REQ-008 ws2812_di SHALL be decoded from registered state/counters only, with no combinational path from any input.
REQ-009 At cyc_cnt = T_BIT-1 the shift register SHALL shift left by 1 and bit_cnt SHALL increment.
REQ-010 After bit 23 completes: if led_cnt = LED_NUM-1, the FSM SHALL go to RST. Otherwise led_cnt SHALL increment and the FSM SHALL go to LOAD. The 1-cycle LOAD gap extends the previous bit's low time.
REQ-011 RST SHALL hold ws2812_di=0 for exactly T_RST cycles. On the last cycle frame_done=1, and the FSM SHALL then go to LOAD (led_cnt=0) if pending=1, else to IDLE.
REQ-012 ws2812_start=1 in any state other than IDLE SHALL set pending=1 without disturbing the frame in progress.
- pending SHALL clear when RST exits to LOAD.
- Multiple requests during one frame SHALL collapse into one.
- A request in the last RST cycle SHALL be honoured.
REQ-013 Exactly LED_NUM cfg_start pulses SHALL be issued per frame, so a wrapping 6-bit index in the config module returns to 0 at frame end.
REQ-014 Counter widths SHALL be:
- cyc_cnt and the RST counter sized for max(T_BIT, T_RST)
- bit_cnt 5 bits
- led_cnt sized for LED_NUM
No counter SHALL wrap within its state.
REQ-015 busy SHALL be 1 in LOAD, SEND and RST, and 0 in IDLE.

Reset
REQ-016 While sys_rst_n=0, independent of the clock:
- state=IDLE
- all counters, the shift register and pending = 0
- ws2812_di=0, cfg_start=0, busy=0, frame_done=0
REQ-017 Reset asserted mid-frame SHALL abort immediately with ws2812_di=0. After release the block SHALL stay in IDLE until a new ws2812_start.

Verification
REQ-018 Reset release with no start for 10k cycles -> ws2812_di=0, busy=0, and no cfg_start pulses.
REQ-019 Single start with cfg_data=24'hFF0000 held -> cfg_start 1 cycle later. Then:
- first 8 bits each 40 high / 20 low
- next 16 bits each 18 high / 42 low
REQ-020 Full frame with model index 0..63 and cfg_data={index,8'h00,~index}:
- 64 cfg_start pulses
- decoded pixel k equals the model value for k
- frame length = 64*(24*60+1) + 15000 cycles
- frame_done pulses once
REQ-021 ws2812_start asserted during SEND of pixel 10, and again during RST:
- the frame is unaffected
- exactly one new frame starts the cycle after frame_done
- pending=0 afterwards
REQ-022 sys_rst_n pulled low during bit 5 of pixel 3 -> ws2812_di=0 and busy=0 immediately. After release plus start, pixel 0 is sent again.
REQ-023 cfg_data changes on every cycle outside LOAD -> only the value present on the LOAD edge is transmitted.

Source files
------------

// File: rtl/ws2812_tx_ctrl.sv
// WS2812 frame transmitter: pulls LED_NUM pixels from a config module and serialises
// them as 24-bit GRB words with bit-width encoding, followed by a latch low period.
module ws2812_tx_ctrl #(
    parameter int unsigned T_BIT   = 60,
    parameter int unsigned T0H     = 18,
    parameter int unsigned T1H     = 40,
    parameter int unsigned T_RST   = 15000,
    parameter int unsigned LED_NUM = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        ws2812_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_start,
    output logic        ws2812_di,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned CNT_MAX = (T_BIT > T_RST) ? T_BIT : T_RST;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned LED_W   = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] HI_ONE   = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] HI_ZERO  = CNT_W'(T0H);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_NUM - 1);
    localparam logic [4:0]       BIT_MSB  = 5'd23;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StRst
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [4:0]       bit_q, bit_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [23:0]      shreg_q, shreg_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] hi_len;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            bit_q     <= '0;
            led_q     <= '0;
            shreg_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            led_q     <= led_d;
            shreg_q   <= shreg_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        led_d     = led_q;
        shreg_d   = shreg_q;
        pending_d = pending_q;

        // Requests while a frame is running collapse into a single pending flag.
        if (ws2812_start && (state_q != StIdle)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (ws2812_start) begin
                    state_d = StLoad;
                    led_d   = '0;
                end
            end
            StLoad: begin
                shreg_d = cfg_data;
                bit_d   = '0;
                cyc_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    shreg_d = {shreg_q[22:0], 1'b0};
                    bit_d   = bit_q + 5'd1;
                    if (bit_q == BIT_MSB) begin
                        if (led_q == LED_LAST) begin
                            state_d = StRst;
                        end else begin
                            led_d   = led_q + 1'b1;
                            state_d = StLoad;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StRst: begin
                if (cyc_q == RST_LAST) begin
                    cyc_d = '0;
                    // A request landing in the final latch cycle still counts.
                    if (pending_q || ws2812_start) begin
                        state_d   = StLoad;
                        led_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hi_len     = shreg_q[23] ? HI_ONE : HI_ZERO;
        cfg_start  = (state_q == StLoad);
        busy       = (state_q != StIdle);
        frame_done = (state_q == StRst) && (cyc_q == RST_LAST);
        ws2812_di  = (state_q == StSend) && (cyc_q < hi_len);
    end

endmodule

// File: tb/tb_ws2812_tx_ctrl.sv
// Scoreboard bench for ws2812_tx_ctrl: a monitor decodes the serial line into pixels and
// frames and compares them against expectations queued when each frame is requested.
module tb_ws2812_tx_ctrl;

    localparam int T_BIT     = 60;
    localparam int T0H       = 18;
    localparam int T1H       = 40;
    localparam int T_RST     = 200;
    localparam int LED_NUM   = 4;
    localparam int FRAME_LEN = LED_NUM * (24 * T_BIT + 1) + T_RST;
    localparam int BUDGET    = 20000;

    localparam int M_MODEL = 0;
    localparam int M_CONST = 1;
    localparam int M_NOISE = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        ws2812_start;
    logic [23:0] cfg_data;
    logic        cfg_start;
    logic        ws2812_di;
    logic        busy;
    logic        frame_done;

    ws2812_tx_ctrl #(
        .T_BIT  (T_BIT),
        .T0H    (T0H),
        .T1H    (T1H),
        .T_RST  (T_RST),
        .LED_NUM(LED_NUM)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .ws2812_start(ws2812_start),
        .cfg_data    (cfg_data),
        .cfg_start   (cfg_start),
        .ws2812_di   (ws2812_di),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_err    = 0;
    int mode     = M_MODEL;
    int idx;

    logic [23:0] exp_pix[$];
    int          exp_len[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] model(input int k);
        logic [7:0] g;
        g = k[7:0];
        return {g, 8'h00, ~g};
    endfunction

    // Config-module model: index advances on each consumed pixel.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) idx <= 0;
        else if (cfg_start) idx <= (idx + 1) % LED_NUM;
    end

    always @(negedge sys_clk) begin
        case (mode)
            M_CONST: cfg_data = 24'hFF0000;
            M_NOISE: cfg_data = cfg_start ? model(idx) : 24'($urandom);
            default: cfg_data = model(idx);
        endcase
    end

    // Line monitor / decoder
    int          cyc, last_rise, hi_len, bit_idx, frame_cnt, starts_in_frame;
    logic        prev_di, first_bit, bad;
    logic [23:0] pix;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_di = 1'b0; hi_len = 0; bit_idx = 0; first_bit = 1'b1; bad = 1'b0;
            frame_cnt = 0; starts_in_frame = 0; cyc = 0; last_rise = 0; pix = '0;
        end else begin
            cyc++;
            if (busy) frame_cnt++;
            if (cfg_start) starts_in_frame++;
            if (ws2812_di) begin
                if (!prev_di) begin
                    if (!first_bit && (cyc - last_rise) != ((bit_idx == 0) ? T_BIT + 1 : T_BIT))
                        bad = 1'b1;
                    first_bit = 1'b0;
                    last_rise = cyc;
                    hi_len    = 0;
                end
                hi_len++;
            end else if (prev_di) begin
                if (hi_len == T1H) pix = {pix[22:0], 1'b1};
                else begin
                    if (hi_len != T0H) bad = 1'b1;
                    pix = {pix[22:0], 1'b0};
                end
                bit_idx++;
                if (bit_idx == 24) begin
                    bit_idx = 0;
                    if (exp_pix.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL pixel_unexpected: got %0h, expected none", pix);
                    end else begin
                        check("pixel_value", 32'(pix), 32'(exp_pix.pop_front()));
                        check("bit_timing", 32'(bad), 32'd0);
                    end
                    bad = 1'b0;
                end
            end
            prev_di = ws2812_di;
            if (frame_done) begin
                if (exp_len.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL frame_unexpected: got len %0d, expected none", frame_cnt);
                end else begin
                    check("frame_len", 32'(frame_cnt), 32'(exp_len.pop_front()));
                end
                check("cfg_start_per_frame", 32'(starts_in_frame), 32'(LED_NUM));
                frame_cnt = 0;
                starts_in_frame = 0;
                first_bit = 1'b1;
            end
        end
    end

    task automatic push_frame(input int m);
        for (int k = 0; k < LED_NUM; k++) exp_pix.push_back((m == M_CONST) ? 24'hFF0000 : model(k));
        exp_len.push_back(FRAME_LEN);
    endtask

    task automatic pulse_start();
        ws2812_start = 1'b1;
        @(posedge sys_clk);
        #1 ws2812_start = 1'b0;
    endtask

    task automatic wait_frame_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!frame_done && n < BUDGET);
        check(name, 32'(frame_done), 32'd1);
    endtask

    task automatic wait_cfg_starts(input int cnt, input string name);
        int seen, n;
        seen = 0;
        n = 0;
        while (seen < cnt && n < BUDGET) begin
            @(negedge sys_clk);
            n++;
            if (cfg_start) seen++;
        end
        check(name, 32'(seen), 32'(cnt));
    endtask

    initial begin
        logic activity;
        sys_rst_n    = 1'b0;
        ws2812_start = 1'b0;
        cfg_data     = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_di", 32'(ws2812_di), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_start", 32'(cfg_start), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        sys_rst_n = 1'b1;

        // Idle after reset release
        activity = 1'b0;
        repeat (10000) begin
            @(negedge sys_clk);
            activity |= ws2812_di | busy | cfg_start | frame_done;
        end
        check("idle_quiet", 32'(activity), 32'd0);

        // Constant FF0000 frame: start-to-cfg_start latency and 40/18 high widths
        mode = M_CONST;
        push_frame(M_CONST);
        @(negedge sys_clk);
        ws2812_start = 1'b1;
        check("start_cfg_start_before", 32'(cfg_start), 32'd0);
        @(negedge sys_clk);
        ws2812_start = 1'b0;
        check("start_cfg_start_after", 32'(cfg_start), 32'd1);
        check("start_busy_after", 32'(busy), 32'd1);
        wait_frame_done("const_frame_done");
        @(negedge sys_clk);
        check("const_busy_end", 32'(busy), 32'd0);

        // Indexed model frame
        mode = M_MODEL;
        push_frame(M_MODEL);
        pulse_start();
        wait_frame_done("model_frame_done");

        // Requests during SEND of pixel 2 and during RST give exactly one more frame
        push_frame(M_MODEL);
        pulse_start();
        wait_cfg_starts(3, "pend_reach_pix2");
        repeat (100) @(negedge sys_clk);
        pulse_start();
        repeat (3) @(negedge sys_clk);
        pulse_start();
        push_frame(M_MODEL);
        wait_cfg_starts(1, "pend_reach_pix3");
        repeat (24 * T_BIT + 21) @(negedge sys_clk);
        pulse_start();
        wait_frame_done("pend_frame1_done");
        @(negedge sys_clk);
        check("pend_next_frame", 32'(cfg_start), 32'd1);
        wait_frame_done("pend_frame2_done");
        @(negedge sys_clk);
        check("pend_cleared_busy", 32'(busy), 32'd0);
        activity = 1'b0;
        repeat (100) begin
            @(negedge sys_clk);
            activity |= cfg_start | busy;
        end
        check("pend_no_third", 32'(activity), 32'd0);

        // Reset during bit 5 of pixel 3 aborts; pixels 0..2 decoded before that
        for (int k = 0; k < 3; k++) exp_pix.push_back(model(k));
        pulse_start();
        wait_cfg_starts(4, "abort_reach_pix3");
        repeat (5 * T_BIT + 11) @(negedge sys_clk);
        check("abort_di_high", 32'(ws2812_di), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("abort_di", 32'(ws2812_di), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pix_drained", 32'(exp_pix.size()), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        push_frame(M_MODEL);
        pulse_start();
        wait_frame_done("abort_refresh_done");

        // Noisy cfg_data outside LOAD; a start in the last RST cycle is honoured
        mode = M_NOISE;
        push_frame(M_MODEL);
        pulse_start();
        wait_frame_done("noise_frame_done");
        @(negedge sys_clk);
        check("noise_busy_end", 32'(busy), 32'd0);
        push_frame(M_MODEL);
        pulse_start();
        push_frame(M_MODEL);
        wait_frame_done("late_frame1_done");
        ws2812_start = 1'b1;
        @(posedge sys_clk);
        #1 ws2812_start = 1'b0;
        @(negedge sys_clk);
        check("late_start_honoured", 32'(cfg_start), 32'd1);
        wait_frame_done("late_frame2_done");
        @(negedge sys_clk);
        check("late_busy_end", 32'(busy), 32'd0);

        check("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
        check("len_queue_empty", 32'(exp_len.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
